// File: rtl/ram_pkt_buf_pkg.sv
// Shared definitions for the store-and-forward packet buffer controller:
// the FSM state encoding and the statistics counter width.
package ram_pkt_buf_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/ram_pkt_buf_ram.sv
// Dual-port buffer RAM: synchronous write port, asynchronous (combinational) read port.
module ram_pkt_buf_ram #(
    parameter int W     = 8,
    parameter int D     = 16,
    parameter int D_LOG = $clog2(D)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [D_LOG-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [D_LOG-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_pkt_buf_ctrl.sv
// Store-and-forward packet controller: fills an external async-read RAM with one
// packet, then replays it. Optional statistics counters under RAM_PKT_BUF_CNT_EN.
module ram_pkt_buf_ctrl
    import ram_pkt_buf_pkg::*;
#(
    parameter int W     = 8,
    parameter int D     = 16,
    parameter int D_LOG = $clog2(D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             ram_wr,
    output logic [D_LOG-1:0] ram_addr_wr,
    output logic [W-1:0]     ram_data_wr,
    output logic [D_LOG-1:0] ram_addr_rd,
    input  logic [W-1:0]     ram_data_rd,
    output logic [D_LOG:0]   pkt_len,
`ifdef RAM_PKT_BUF_CNT_EN
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
`endif
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam logic [D_LOG-1:0] LAST_ADDR = D_LOG'(D - 1);

    state_e           state_q, state_d;
    logic [D_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [D_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [D_LOG-1:0] last_idx_q, last_idx_d;
    logic             overflow_q, overflow_d;
`ifdef RAM_PKT_BUF_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

    logic in_hs;
    logic out_hs;

    // in_ready is gated by rst_n so the source sees no acceptance during reset.
    assign in_ready    = rst_n && (state_q != ST_DRAIN);
    assign in_hs       = in_valid && in_ready;
    assign out_valid   = (state_q == ST_DRAIN);
    assign out_last    = out_valid && (rd_ptr_q == last_idx_q);
    assign out_hs      = out_valid && out_ready;
    assign out_data    = ram_data_rd;
    assign ram_wr      = in_hs && (state_q == ST_FILL);
    assign ram_addr_wr = wr_ptr_q;
    assign ram_data_wr = in_data;
    assign ram_addr_rd = rd_ptr_q;
    assign pkt_len     = {1'b0, last_idx_q} + (D_LOG + 1)'(1);
    assign overflow    = overflow_q;
`ifdef RAM_PKT_BUF_CNT_EN
    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_idx_d = last_idx_q;
        overflow_d = overflow_q;
`ifdef RAM_PKT_BUF_CNT_EN
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
`endif
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                if (in_hs) begin
                    last_idx_d = wr_ptr_q;
                    // The pointer holds at the top address instead of wrapping.
                    if (wr_ptr_q != LAST_ADDR) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (in_hs) begin
`ifdef RAM_PKT_BUF_CNT_EN
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
`endif
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    if (out_last) begin
                        state_d  = ST_FILL;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
`ifdef RAM_PKT_BUF_CNT_EN
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
`endif
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_idx_q <= '0;
            overflow_q <= 1'b0;
`ifdef RAM_PKT_BUF_CNT_EN
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_idx_q <= last_idx_d;
            overflow_q <= overflow_d;
`ifdef RAM_PKT_BUF_CNT_EN
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

endmodule

// File: doc/ram_pkt_buf_ctrl.md
Name: ram_pkt_buf_ctrl

Overview:
- Store-and-forward packet controller that sequences a dual-port RAM with synchronous write and asynchronous read.
- Accepts one packet from a valid/ready source into the RAM, then replays it to a valid/ready sink.
- Sits between the upstream stream interface and the buffer RAM. The integration top instantiates the controller and the RAM side by side.

Parameters:
- W, 8, data width in bits; matches the RAM data width.
- D, 16, RAM depth in words; also the maximum packet length.
- D_LOG, $clog2(D), RAM address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  W  source data
- in_valid  in  1  source word valid
- in_last  in  1  marks the final word of a packet
- in_ready  out  1  controller accepts a source word
- out_data  out  W  sink data
- out_valid  out  1  sink word valid
- out_last  out  1  marks the final word on the sink side
- out_ready  in  1  sink accepts a word
- ram_wr  out  1  RAM write enable
- ram_addr_wr  out  D_LOG  RAM write address
- ram_data_wr  out  W  RAM write data
- ram_addr_rd  out  D_LOG  RAM read address
- ram_data_rd  in  W  RAM asynchronous read data
- pkt_len  out  D_LOG+1  length of the stored packet; valid in DRAIN
- overflow  out  1  sticky truncation flag
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state:
  - State is FILL; wr_ptr=0, rd_ptr=0, last_idx=0, overflow=0.
  - in_ready=0 and ram_wr=0 while rst_n is low.
  - out_valid=0 and out_last=0.
- Handshakes: a word transfers on a cycle where valid and ready are both high. valid must not depend on ready.
- ram_data_wr=in_data and ram_addr_wr=wr_ptr, combinationally. ram_wr = in_valid & in_ready & (state==FILL).
- ram_addr_rd=rd_ptr. out_data=ram_data_rd combinationally (zero latency, because the RAM read is asynchronous).
- FILL state:
  - in_ready=1, out_valid=0.
  - On each accepted word: write it to the RAM, set last_idx<=wr_ptr, and increment wr_ptr.
  - Accepted word with in_last=1 -> go to DRAIN.
  - Accepted word at wr_ptr==D-1 with in_last=0 -> truncate the packet (the stored packet is D words), set overflow, go to DISCARD.
- DISCARD state:
  - in_ready=1, ram_wr=0; incoming words are dropped.
  - Accepted word with in_last=1 -> go to DRAIN.
- DRAIN state:
  - in_ready=0, out_valid=1, out_last=(rd_ptr==last_idx), pkt_len=last_idx+1.
  - On each sink handshake, rd_ptr increments.
  - Handshake with out_last=1 -> go to FILL; wr_ptr and rd_ptr reset to 0.
- Packet lengths:
  - Minimum packet is 1 word: in_last on the first word gives last_idx=0.
  - Zero-length packets do not exist.
- Back-pressure: out_ready may stay low indefinitely. out_valid stays high and out_data stays stable while out_ready is low.
- Overflow flag: overflow is sticky.
  - ovf_clr=1 clears it on the next edge.
  - If ovf_clr and a new truncation occur in the same cycle, set wins.
- Simultaneous events: input and output never handshake in the same cycle, because the states are exclusive.
- Reset mid-operation: rst_n low in any state returns immediately to the reset state. The partial packet is abandoned and the RAM contents are don't-care.
- Widths: pointers are D_LOG bits and never wrap. The D-1 limit is checked explicitly, so D need not be a power of two.

Optional Feature:
- Macro: RAM_PKT_BUF_CNT_EN.
- With the macro defined:
  - Adds output pkt_cnt[15:0], reset to 0.
  - pkt_cnt increments on each out_last handshake and wraps from 0xFFFF to 0.
  - Adds output drop_cnt[15:0], which counts words discarded in DISCARD and saturates at 0xFFFF.
- Without the macro: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package ram_pkt_buf_pkg:
  - State encoding: ST_FILL=2'd0, ST_DISCARD=2'd1, ST_DRAIN=2'd2.
  - Width constant for the counter: CNT_W=16.
- No sub-module inside the controller; the single FSM and its pointers are the whole block.
- The RAM remains external. The test bench and integration top instantiate the existing dual-port async-read RAM with W=8, D=16.

Test Plan:
- Single-word packet: 0xA5 with in_last -> one DRAIN beat with out_data=0xA5, out_last=1, pkt_len=1; back to FILL after the handshake.
- Four-word packet 0x01..0x04, out_ready held high -> four consecutive beats 0x01..0x04, out_last only on 0x04, pkt_len=4.
- Overflow:
  - Stimulus: 20-word packet 0x00..0x13 with last on 0x13.
  - Required response: sink sees 16 beats 0x00..0x0F with out_last on 0x0F, overflow=1; with the macro defined, drop_cnt=4.
  - Then ovf_clr pulse -> overflow=0.
- Back-pressure: 3-word packet with out_ready toggling 1,0,0,1,0,1 -> out_data stable while stalled, exactly 3 handshakes; in_ready=0 throughout DRAIN.
- Reset mid-operation: rst_n pulsed low after 2 of 5 words are accepted -> in_ready=0 and out_valid=0 during reset. Next packet 0x10,0x11 (last) drains as exactly 2 beats, pkt_len=2.
- Back-to-back packets: five packets of lengths 1,16,2,8,3 with random valid/ready -> all data matches a scoreboard; with the macro defined, pkt_cnt=5.
